// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the multi-channel byte-serial memory port arbiter.
`define ChBus(n, w) [(n)*(w)-1:0]

package mem_port_arbiter_pkg;

    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b11;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    typedef enum logic [1:0] {
        MA_IDLE  = 2'b00,
        MA_XFER  = 2'b01,
        MA_DRAIN = 2'b10
    } ma_state_e;

    // Index of the last byte of a transfer; the unused 10 code behaves as a word.
    function automatic logic [1:0] len_last(input logic [1:0] len);
        logic [1:0] last;
        case (len)
            LEN_B:   last = 2'd0;
            LEN_H:   last = 2'd1;
            default: last = 2'd3;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb.sv
// Winner select across request channels: fixed priority or round-robin from a stored pointer.
module mem_rr_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int PRIO_MODE = 0,
    localparam int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_take,
    input  logic [NUM_CH-1:0] i_req,
    output logic              o_valid,
    output logic [IDX_W-1:0]  o_winner
);

    logic [IDX_W-1:0] r_ptr;
    int               w_start;
    int               w_idx;

    // Scan channels starting at the pointer (round-robin) or at channel 0 (fixed).
    always_comb begin
        w_start  = (PRIO_MODE == PRIO_RR) ? int'(r_ptr) : 0;
        w_idx    = 0;
        o_valid  = 1'b0;
        o_winner = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = (w_start + i) % NUM_CH;
            if (!o_valid && i_req[w_idx]) begin
                o_valid  = 1'b1;
                o_winner = IDX_W'(w_idx);
            end else begin
                o_valid  = o_valid;
            end
        end
    end

    // Pointer moves past the winner on every accepted grant.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_take && o_valid) begin
            r_ptr <= (o_winner == IDX_W'(NUM_CH - 1)) ? '0 : o_winner + 1'b1;
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises per-channel byte/halfword/word requests onto an 8-bit RAM bus with
// one cycle of read latency; rdy low freezes the engine.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_rdy,
    input  logic [NUM_CH-1:0]       i_req,
    input  logic [NUM_CH-1:0]       i_req_wr,
    input  logic `ChBus(NUM_CH, 2)  i_req_len,
    input  logic `ChBus(NUM_CH, ADDR_W) i_req_addr,
    input  logic `ChBus(NUM_CH, 32) i_req_wdata,
    output logic [NUM_CH-1:0]       o_gnt,
    output logic [NUM_CH-1:0]       o_almost_done,
    output logic [NUM_CH-1:0]       o_done,
    output logic [31:0]             o_rdata,
    input  logic [7:0]              i_din_ram,
    output logic [7:0]              o_dout_ram,
    output logic [ADDR_W-1:0]       o_addr_ram,
    output logic                    o_wr_ram
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    ma_state_e         r_state;
    ma_state_e         w_next_state;
    logic [1:0]        r_cnt;
    logic [1:0]        r_last;
    logic [IDX_W-1:0]  r_ch;
    logic              r_wr;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_wdata;
    logic [31:0]       r_acc;
    logic [31:0]       r_rdata;
    logic              r_refetch;

    logic              w_take;
    logic              w_arb_valid;
    logic [IDX_W-1:0]  w_win;
    logic              w_sel_wr;
    logic [1:0]        w_sel_last;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic              w_refetch_now;
    logic              w_step;
    logic [1:0]        w_prev_cnt;
    logic [31:0]       w_rdata_asm;

    assign w_take        = (r_state == MA_IDLE) && i_rdy;
    assign w_refetch_now = r_refetch && i_rdy;
    assign w_step        = i_rdy && !r_refetch;
    assign w_prev_cnt    = r_cnt - 2'd1;

    mem_rr_arbiter #(
        .NUM_CH    (NUM_CH),
        .PRIO_MODE (PRIO_MODE)
    ) u_arb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_take   (w_take),
        .i_req    (i_req),
        .o_valid  (w_arb_valid),
        .o_winner (w_win)
    );

    // Request fields of the current arbitration winner.
    always_comb begin
        w_sel_wr    = i_req_wr[w_win];
        w_sel_last  = len_last(i_req_len[int'(w_win)*2 +: 2]);
        w_sel_addr  = i_req_addr[int'(w_win)*ADDR_W +: ADDR_W];
        w_sel_wdata = i_req_wdata[int'(w_win)*32 +: 32];
    end

    // Read result with the final byte taken straight from the bus.
    always_comb begin
        w_rdata_asm = r_acc;
        w_rdata_asm[{r_last, 3'b000} +: 8] = i_din_ram;
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= MA_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a pending refetch cycle never advances the transfer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MA_IDLE: begin
                if (i_rdy && w_arb_valid) w_next_state = MA_XFER;
                else                      w_next_state = MA_IDLE;
            end
            MA_XFER: begin
                if (w_step && (r_cnt == r_last)) w_next_state = r_wr ? MA_IDLE : MA_DRAIN;
                else                             w_next_state = MA_XFER;
            end
            MA_DRAIN: begin
                if (w_step) w_next_state = MA_IDLE;
                else        w_next_state = MA_DRAIN;
            end
            default: w_next_state = MA_IDLE;
        endcase
    end

    // Transaction latches, byte counter, read assembly and refetch tracking.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= 2'd0;
            r_last    <= 2'd0;
            r_ch      <= '0;
            r_wr      <= 1'b0;
            r_base    <= '0;
            r_wdata   <= 32'd0;
            r_acc     <= 32'd0;
            r_rdata   <= 32'd0;
            r_refetch <= 1'b0;
        end else if (i_rdy) begin
            r_refetch <= 1'b0;
            case (r_state)
                MA_IDLE: begin
                    if (w_arb_valid) begin
                        r_cnt   <= 2'd0;
                        r_last  <= w_sel_last;
                        r_ch    <= w_win;
                        r_wr    <= w_sel_wr;
                        r_base  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_acc   <= 32'd0;
                    end
                end
                MA_XFER: begin
                    if (!r_refetch) begin
                        if (!r_wr && (r_cnt != 2'd0)) r_acc[{w_prev_cnt, 3'b000} +: 8] <= i_din_ram;
                        if (r_cnt != r_last)          r_cnt <= r_cnt + 2'd1;
                    end
                end
                MA_DRAIN: begin
                    if (!r_refetch) r_rdata <= w_rdata_asm;
                end
                default: r_cnt <= 2'd0;
            endcase
        end else begin
            // The byte now on din_ram is lost while frozen, so its address is re-driven later.
            if (((r_state == MA_XFER) && !r_wr && (r_cnt != 2'd0)) || (r_state == MA_DRAIN))
                r_refetch <= 1'b1;
        end
    end

    // Bus drive and channel pulses.
    always_comb begin
        o_gnt         = '0;
        o_almost_done = '0;
        o_done        = '0;
        o_rdata       = r_rdata;
        o_dout_ram    = 8'd0;
        o_addr_ram    = '0;
        o_wr_ram      = 1'b0;
        if (i_rst) begin
            o_rdata = 32'd0;
        end else begin
            case (r_state)
                MA_IDLE: begin
                    if (i_rdy && w_arb_valid) begin
                        o_gnt[w_win] = 1'b1;
                        o_almost_done[w_win] = w_sel_wr && (w_sel_last == 2'd0);
                    end else begin
                        o_gnt = '0;
                    end
                end
                MA_XFER: begin
                    o_addr_ram = w_refetch_now ? r_base + ADDR_W'(w_prev_cnt) : r_base + ADDR_W'(r_cnt);
                    o_dout_ram = r_wr ? r_wdata[{r_cnt, 3'b000} +: 8] : 8'd0;
                    o_wr_ram   = r_wr && i_rdy;
                    if (w_step) begin
                        if (r_wr) begin
                            o_done[r_ch]        = (r_cnt == r_last);
                            o_almost_done[r_ch] = ((r_cnt + 2'd1) == r_last);
                        end else begin
                            o_almost_done[r_ch] = (r_cnt == r_last);
                        end
                    end else begin
                        o_done = '0;
                    end
                end
                MA_DRAIN: begin
                    if (w_refetch_now) begin
                        o_addr_ram          = r_base + ADDR_W'(r_last);
                        o_almost_done[r_ch] = 1'b1;
                    end else if (i_rdy) begin
                        o_done[r_ch] = 1'b1;
                        o_rdata      = w_rdata_asm;
                    end else begin
                        o_done = '0;
                    end
                end
                default: o_wr_ram = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench: one fixed-priority and one round-robin instance share stimulus.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [1:0]  req, req_wr;
    logic [3:0]  req_len;
    logic [63:0] req_addr, req_wdata;

    logic [1:0]  gnt_f, alm_f, done_f, gnt_r, alm_r, done_r;
    logic [31:0] rdata_f, rdata_r, addr_f, addr_r;
    logic [7:0]  din_f, din_r, dout_f, dout_r;
    logic        wr_f, wr_r;

    logic [7:0]  mem [0:4095];
    int          n_vec = 0;
    int          n_err = 0;
    logic [1:0]  g_f [0:3];
    logic [1:0]  g_r [0:3];
    int          nf, nr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_CH(2), .ADDR_W(32), .PRIO_MODE(0)) dut_fix (
        .i_clk(clk), .i_rst(rst), .i_rdy(rdy), .i_req(req), .i_req_wr(req_wr),
        .i_req_len(req_len), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_gnt(gnt_f), .o_almost_done(alm_f), .o_done(done_f), .o_rdata(rdata_f),
        .i_din_ram(din_f), .o_dout_ram(dout_f), .o_addr_ram(addr_f), .o_wr_ram(wr_f)
    );

    mem_port_arbiter #(.NUM_CH(2), .ADDR_W(32), .PRIO_MODE(1)) dut_rr (
        .i_clk(clk), .i_rst(rst), .i_rdy(rdy), .i_req(req), .i_req_wr(req_wr),
        .i_req_len(req_len), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_gnt(gnt_r), .o_almost_done(alm_r), .o_done(done_r), .o_rdata(rdata_r),
        .i_din_ram(din_r), .o_dout_ram(dout_r), .o_addr_ram(addr_r), .o_wr_ram(wr_r)
    );

    // Byte RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (wr_f) mem[addr_f[11:0]] <= dout_f;
        din_f <= mem[addr_f[11:0]];
    end

    always @(posedge clk) din_r <= mem[addr_r[11:0]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_ch(input int ch, input logic wr, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] wd);
        req[ch]             = 1'b1;
        req_wr[ch]          = wr;
        req_len[ch*2 +: 2]  = len;
        req_addr[ch*32 +: 32]  = addr;
        req_wdata[ch*32 +: 32] = wd;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
        mem[12'h100] <= 8'h11;
        mem[12'h101] <= 8'h22;
        mem[12'h102] <= 8'h33;
        mem[12'h103] <= 8'h44;
        mem[12'h104] <= 8'h5A;
        mem[12'hFFF] <= 8'h77;
        mem[12'h000] <= 8'h66;
        rst = 1'b1; rdy = 1'b1; req = 2'b11; req_wr = 2'b00;
        req_len = 4'd0; req_addr = 64'd0; req_wdata = 64'd0;

        // Reset state, with requests present
        cyc(); settle();
        check("rst_gnt", gnt_f, 2'b00);
        check("rst_alm", alm_f, 2'b00);
        check("rst_done", done_f, 2'b00);
        check("rst_rdata", rdata_f, 32'd0);
        check("rst_bus", {wr_f, dout_f, addr_f}, 41'd0);
        req = 2'b00;
        cyc(); rst = 1'b0;

        // Ch0 4-byte read from 0x100
        cyc(); set_ch(0, 1'b0, 2'b11, 32'h100, 32'd0); settle();
        check("rd_gnt", gnt_f, 2'b01);
        check("rd_alm0", alm_f, 2'b00);
        for (int k = 0; k < 4; k++) begin
            cyc(); req = 2'b00; settle();
            check("rd_addr", addr_f, 32'h100 + k);
            check("rd_wr", wr_f, 1'b0);
            check("rd_done_early", done_f, 2'b00);
            check("rd_alm", alm_f, (k == 3) ? 2'b01 : 2'b00);
        end
        cyc(); settle();
        check("rd_done", done_f, 2'b01);
        check("rd_rdata", rdata_f, 32'h44332211);
        check("rd_drain_addr", addr_f, 32'd0);
        cyc(); settle();
        check("rd_done_once", done_f, 2'b00);
        check("rd_rdata_hold", rdata_f, 32'h44332211);

        // Ch1 halfword write 0xABCD to 0x200
        cyc(); set_ch(1, 1'b1, 2'b01, 32'h200, 32'h0000ABCD); settle();
        check("wr_gnt", gnt_f, 2'b10);
        check("wr_alm0", alm_f, 2'b00);
        cyc(); req = 2'b00; settle();
        check("wr_b0", {wr_f, dout_f, addr_f}, {1'b1, 8'hCD, 32'h200});
        check("wr_alm", alm_f, 2'b10);
        check("wr_done_early", done_f, 2'b00);
        cyc(); settle();
        check("wr_b1", {wr_f, dout_f, addr_f}, {1'b1, 8'hAB, 32'h201});
        check("wr_done", done_f, 2'b10);
        cyc(); settle();
        check("wr_idle", {wr_f, gnt_f}, 3'd0);
        check("wr_mem", {mem[12'h201], mem[12'h200]}, 16'hABCD);

        // Arbitration: both channels keep requesting 1-byte reads
        rst = 1'b1; cyc(); rst = 1'b0;
        set_ch(0, 1'b0, 2'b00, 32'h104, 32'd0);
        set_ch(1, 1'b0, 2'b00, 32'h104, 32'd0);
        nf = 0; nr = 0;
        for (int c = 0; c < 12; c++) begin
            settle();
            if (gnt_f != 2'b00) begin
                if (nf < 4) g_f[nf] = gnt_f;
                nf++;
            end
            if (gnt_r != 2'b00) begin
                if (nr < 4) g_r[nr] = gnt_r;
                nr++;
            end
            cyc();
        end
        req = 2'b00;
        check("arb_fix_count", nf, 4);
        check("arb_rr_count", nr, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < nf) check("arb_fix_seq", g_f[i], 2'b01);
            if (i < nr) check("arb_rr_seq", g_r[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        settle();
        check("arb_rdata_byte", rdata_f, 32'h0000005A);

        // rdy stall during byte 2 of a word read (len 10 acts as word)
        set_ch(0, 1'b0, 2'b10, 32'h100, 32'd0); settle();
        check("st_gnt", gnt_f, 2'b01);
        cyc(); req = 2'b00; settle();
        check("st_addr0", addr_f, 32'h100);
        cyc(); settle();
        check("st_addr1", addr_f, 32'h101);
        for (int s = 0; s < 3; s++) begin
            cyc(); rdy = 1'b0; settle();
            check("st_hold_addr", addr_f, 32'h102);
            check("st_pulses", {wr_f, gnt_f, alm_f, done_f}, 7'd0);
            check("st_rdata", rdata_f, 32'h0000005A);
        end
        cyc(); rdy = 1'b1; settle();
        check("st_refetch", addr_f, 32'h101);
        check("st_refetch_pulse", {alm_f, done_f}, 4'd0);
        cyc(); settle();
        check("st_addr2", addr_f, 32'h102);
        cyc(); settle();
        check("st_addr3", addr_f, 32'h103);
        check("st_alm", alm_f, 2'b01);
        cyc(); settle();
        check("st_done", done_f, 2'b01);
        check("st_rdata_final", rdata_f, 32'h44332211);

        // Reset in the middle of a word write
        cyc(); set_ch(0, 1'b1, 2'b11, 32'h400, 32'hDEADBEEF); settle();
        check("rw_gnt", gnt_f, 2'b01);
        cyc(); req = 2'b00; settle();
        check("rw_b0", {wr_f, dout_f}, {1'b1, 8'hEF});
        cyc(); settle();
        check("rw_b1", {wr_f, dout_f, addr_f}, {1'b1, 8'hBE, 32'h401});
        rst = 1'b1; #1;
        check("rw_async_drop", {wr_f, done_f, addr_f}, 35'd0);
        cyc(); settle();
        check("rw_no_done", {wr_f, done_f}, 3'd0);
        cyc(); rst = 1'b0; settle();
        check("rw_mem", {mem[12'h401], mem[12'h400]}, 16'h00EF);
        cyc(); set_ch(1, 1'b0, 2'b00, 32'h104, 32'd0); settle();
        check("rw_regnt", gnt_f, 2'b10);
        cyc(); req = 2'b00; cyc(); settle();
        check("rw_redone", done_f, 2'b10);
        check("rw_rdata", rdata_f, 32'h0000005A);

        // Halfword read wrapping the address space
        cyc(); set_ch(0, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'd0); settle();
        check("wrap_gnt", gnt_f, 2'b01);
        cyc(); req = 2'b00; settle();
        check("wrap_a0", addr_f, 32'hFFFF_FFFF);
        cyc(); settle();
        check("wrap_a1", addr_f, 32'h0000_0000);
        check("wrap_alm", alm_f, 2'b01);
        cyc(); settle();
        check("wrap_done", done_f, 2'b01);
        check("wrap_rdata", rdata_f, 32'h00006677);

        // 1-byte write of 0x00 to the I/O region, request held
        cyc(); set_ch(0, 1'b1, 2'b00, 32'h0003_0000, 32'd0); settle();
        check("b1_gnt", gnt_f, 2'b01);
        check("b1_alm", alm_f, 2'b01);
        cyc(); settle();
        check("b1_bus", {wr_f, dout_f, addr_f}, {1'b1, 8'h00, 32'h0003_0000});
        check("b1_done", done_f, 2'b01);
        check("b1_no_gnt", gnt_f, 2'b00);
        cyc(); settle();
        check("b1_regnt", gnt_f, 2'b01);
        req = 2'b00;
        cyc(); cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
